// File: rtl/i2s_rx_ctrl_pkg.sv
// i2s_rx_ctrl_pkg
// Shared definitions for the I2S receiver control block:
//   - FSM state encoding (IDLE/SYNC/RUN/DONE)
//   - register byte offsets of the Wishbone window
//   - CTRL / STATUS bit positions
//   - byte_mask(): expands Wishbone byte enables into a 32-bit bit mask
package i2s_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rx_state_e;

  localparam logic [7:0] REG_CTRL         = 8'h00;
  localparam logic [7:0] REG_STATUS       = 8'h04;
  localparam logic [7:0] REG_FRAME_TARGET = 8'h08;
  localparam logic [7:0] REG_FRAME_CNT    = 8'h0C;
  localparam logic [7:0] REG_RX_CFG       = 8'h10;
  localparam logic [7:0] REG_SAMPLE_CNT   = 8'h14;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_ONE_SHOT = 1;
  localparam int CTRL_IE_DONE  = 8;
  localparam int CTRL_IE_OVF   = 9;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_STATE   = 4;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/i2s_ws_edge_sync.sv
// i2s_ws_edge_sync
// Brings the asynchronous I2S word select into the local clock domain with a
// two-flop synchronizer, delays it by one more flop and emits a one-cycle
// pulse on each WS falling edge (start of a new frame).
// Ports:
//   clk_i   - local clock
//   rst_i   - synchronous active-high reset
//   ws_i    - I2S word select, asynchronous
//   edge_o  - one-cycle pulse on synchronized WS falling edge
module i2s_ws_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ws_i,
  output logic edge_o
);

  // sync_q[0] and sync_q[1] form the synchronizer, sync_q[2] is the delay
  // stage used to detect the transition.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], ws_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Falling edge: delayed WS still high while the synchronized WS is low.
  assign edge_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/i2s_rx_ctrl.sv
// i2s_rx_ctrl
// Wishbone-slave control/status block sequencing the I2S receiver. Holds the
// receiver configuration word, aligns receiver enable to a WS falling edge,
// counts frames and samples, stops after a programmed frame count in one-shot
// mode and raises a level interrupt on done/overflow.
// Optional feature macro: I2S_RX_CTRL_TIMEOUT_EN (WS inactivity timeout).
// Ports:
//   wb_clk_i, wb_rst_i             - clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i    - Wishbone classic cycle controls
//   wb_adr_i, wb_sel_i, wb_dat_i   - byte address, byte enables, write data
//   wb_dat_o, wb_ack_o             - registered read data and acknowledge
//   i2s_ws_i                       - asynchronous I2S word select
//   rx_sample_valid_i, rx_overflow_i - receiver event pulses
//   rx_en_o, rx_cfg_o, irq_o       - receiver enable, config word, interrupt
module i2s_rx_ctrl
  import i2s_rx_ctrl_pkg::*;
#(
  parameter int ADR_W   = 5,
  parameter int FCNT_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic             i2s_ws_i,
  input  logic             rx_sample_valid_i,
  input  logic             rx_overflow_i,
  output logic             rx_en_o,
  output logic [31:0]      rx_cfg_o,
  output logic             irq_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  rx_state_e         state_q, state_d;
  logic              enable_q, enable_d, one_shot_q, one_shot_d;
  logic              ie_done_q, ie_done_d, ie_ovf_q, ie_ovf_d;
  logic              done_q, done_d, ovf_q, ovf_d;
  logic [FCNT_W-1:0] target_q, target_d, fcnt_q, fcnt_d;
  logic [31:0]       scnt_q, scnt_d, cfg_q, cfg_d;
  logic              rx_en_q, rx_en_d, irq_q, irq_d;

  logic              acc, wr, busy, frame_edge, done_set, tmo_hit, tmo_flag;
  logic [31:0]       mask;
  logic [ADR_W-1:0]  byte_off;
  logic              unused_bits;

  i2s_ws_edge_sync u_ws_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .ws_i   (i2s_ws_i),
    .edge_o (frame_edge)
  );

  assign unused_bits = ^{wb_adr_i[1:0], 32'(TIMEOUT)};
  assign busy        = (state_q == ST_SYNC) || (state_q == ST_RUN);

`ifdef I2S_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  // Inactivity counter: runs only while busy and restarts on every frame
  // edge; reaching TIMEOUT forces the block back to IDLE.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (busy && !frame_edge) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_d = (timeout_q & ~(wr && byte_off == ADR_W'(REG_STATUS) &&
                      mask[STAT_TIMEOUT] && wb_dat_i[STAT_TIMEOUT])) | tmo_hit;
  assign tmo_flag  = timeout_q;
`else
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  // Bus decode, register writes, W1C status updates and registered read
  // data. A transfer is accepted in the cycle before ack rises, so writes
  // land on the same edge that raises wb_ack_o.
  always_comb begin
    acc        = wb_cyc_i & wb_stb_i & ~ack_q;
    wr         = acc & wb_we_i;
    ack_d      = acc;
    mask       = byte_mask(wb_sel_i);
    byte_off   = {wb_adr_i[ADR_W-1:2], 2'b00};
    enable_d   = enable_q;
    one_shot_d = one_shot_q;
    ie_done_d  = ie_done_q;
    ie_ovf_d   = ie_ovf_q;
    target_d   = target_q;
    cfg_d      = cfg_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    dat_d      = 32'h0;

    if (wr) begin
      if (byte_off == ADR_W'(REG_CTRL)) begin
        if (mask[CTRL_ENABLE])   enable_d   = wb_dat_i[CTRL_ENABLE];
        if (mask[CTRL_ONE_SHOT]) one_shot_d = wb_dat_i[CTRL_ONE_SHOT];
        if (mask[CTRL_IE_DONE])  ie_done_d  = wb_dat_i[CTRL_IE_DONE];
        if (mask[CTRL_IE_OVF])   ie_ovf_d   = wb_dat_i[CTRL_IE_OVF];
      end
      if (byte_off == ADR_W'(REG_STATUS)) begin
        if (mask[STAT_DONE] && wb_dat_i[STAT_DONE]) done_d = 1'b0;
        if (mask[STAT_OVF]  && wb_dat_i[STAT_OVF])  ovf_d  = 1'b0;
      end
      if (byte_off == ADR_W'(REG_FRAME_TARGET)) begin
        target_d = (target_q & ~mask[FCNT_W-1:0]) | (wb_dat_i[FCNT_W-1:0] & mask[FCNT_W-1:0]);
      end
      if (byte_off == ADR_W'(REG_RX_CFG) && !busy) begin
        cfg_d = (cfg_q & ~mask) | (wb_dat_i & mask);
      end
    end

    // Hardware sets take priority over a coincident W1C clear.
    if (done_set)      done_d   = 1'b1;
    if (rx_overflow_i) ovf_d    = 1'b1;
    if (tmo_hit)       enable_d = 1'b0;

    if (acc && !wb_we_i) begin
      case (byte_off)
        ADR_W'(REG_CTRL):         dat_d = {22'h0, ie_ovf_q, ie_done_q, 6'h0, one_shot_q, enable_q};
        ADR_W'(REG_STATUS):       dat_d = {26'h0, state_q, tmo_flag, ovf_q, done_q, busy};
        ADR_W'(REG_FRAME_TARGET): dat_d = 32'(target_q);
        ADR_W'(REG_FRAME_CNT):    dat_d = 32'(fcnt_q);
        ADR_W'(REG_RX_CFG):       dat_d = cfg_q;
        ADR_W'(REG_SAMPLE_CNT):   dat_d = scnt_q;
        default:                  dat_d = 32'h0;
      endcase
    end
  end

  // Sequencer. It looks at the post-write enable so that a disable landing
  // on the same edge as a frame edge wins and the edge is not counted.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    scnt_d   = scnt_q;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_d) begin
          state_d = ST_SYNC;
          fcnt_d  = '0;
          scnt_d  = 32'h0;
        end
      end
      ST_SYNC: begin
        if (!enable_d)      state_d = ST_IDLE;
        else if (frame_edge) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rx_sample_valid_i) scnt_d = scnt_q + 32'h1;
        if (!enable_d) begin
          state_d = ST_IDLE;
        end else if (frame_edge) begin
          fcnt_d = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
          if (one_shot_q && (target_q != '0) && (fcnt_d == target_q)) begin
            state_d  = ST_DONE;
            done_set = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!enable_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rx_en_d = (state_d == ST_RUN);
    irq_d   = (done_q & ie_done_q) | (ovf_q & ie_ovf_q) | (tmo_flag & ie_done_q);
  end

  // All architectural state, cleared by the synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      one_shot_q <= 1'b0;
      ie_done_q  <= 1'b0;
      ie_ovf_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      target_q   <= '0;
      fcnt_q     <= '0;
      scnt_q     <= 32'h0;
      cfg_q      <= 32'h0;
      rx_en_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      state_q    <= state_d;
      enable_q   <= enable_d;
      one_shot_q <= one_shot_d;
      ie_done_q  <= ie_done_d;
      ie_ovf_q   <= ie_ovf_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      target_q   <= target_d;
      fcnt_q     <= fcnt_d;
      scnt_q     <= scnt_d;
      cfg_q      <= cfg_d;
      rx_en_q    <= rx_en_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign rx_en_o  = rx_en_q;
  assign rx_cfg_o = cfg_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// tb_i2s_rx_ctrl
// Directed bench for i2s_rx_ctrl (default build, timeout feature disabled).
// Walks through reset, register access, frame-aligned enable, frame/sample
// counting, disable coincident with a frame edge, one-shot completion with
// interrupt, and overflow status with a coincident W1C.
module tb_i2s_rx_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        cyc, stb, we;
   logic [4:0]  adr;
   logic [3:0]  sel;
   logic [31:0] datIn, datOut, rdData;
   logic        ack, ws, sampleValid, overflow, rxEn, irq;
   logic [31:0] rxCfg;
   int          checkCount = 0;
   int          passCount = 0;
   int          failCount = 0;
   int          latency;
   logic [4:0]  regAddrs [7] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};

   i2s_rx_ctrl dut (
      .wb_clk_i          (clock),
      .wb_rst_i          (reset),
      .wb_cyc_i          (cyc),
      .wb_stb_i          (stb),
      .wb_we_i           (we),
      .wb_adr_i          (adr),
      .wb_sel_i          (sel),
      .wb_dat_i          (datIn),
      .wb_dat_o          (datOut),
      .wb_ack_o          (ack),
      .i2s_ws_i          (ws),
      .rx_sample_valid_i (sampleValid),
      .rx_overflow_i     (overflow),
      .rx_en_o           (rxEn),
      .rx_cfg_o          (rxCfg),
      .irq_o             (irq)
   );

   // 100 MHz clock.
   always #5 clock = ~clock;

   // One comparison: counts it, and counts a pass or reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Advance n cycles, ending 1 ns after a rising edge.
   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drive n WS frames: 4 cycles high, 4 cycles low (one falling edge each).
   task automatic applyStimulus(input int frames);
      for (int f = 0; f < frames; f++) begin
         ws = 1'b1;
         waitCycles(4);
         ws = 1'b0;
         waitCycles(4);
      end
   endtask

   // Wishbone classic write; returns one cycle after the ack.
   task automatic wbWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic seen;
      seen = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; datIn = d; sel = s;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (ack) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("wr_ack_timeout", 32'(seen), 32'h1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      waitCycles(1);
   endtask

   // Wishbone classic read; returns one cycle after the ack.
   task automatic wbRead(input logic [4:0] a, output logic [31:0] d);
      logic seen;
      seen = 1'b0;
      d = 32'hDEAD_BEEF;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         if (ack) begin
            seen = 1'b1;
            d = datOut;
            break;
         end
      end
      if (!seen) checkOutput("rd_ack_timeout", 32'(seen), 32'h1);
      cyc = 1'b0; stb = 1'b0;
      waitCycles(1);
   endtask

   // Directed sequence.
   initial begin
      reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = 4'h0;
      datIn = '0; ws = 1'b1; sampleValid = 1'b0; overflow = 1'b0;
      waitCycles(3);
      checkOutput("rst_ack", 32'(ack), 32'h0);
      checkOutput("rst_dat", datOut, 32'h0);
      checkOutput("rst_rx_en", 32'(rxEn), 32'h0);
      checkOutput("rst_rx_cfg", rxCfg, 32'h0);
      checkOutput("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      waitCycles(1);

      // Every register, plus one unmapped offset, reads zero; ack is a single cycle.
      foreach (regAddrs[k]) begin
         wbRead(regAddrs[k], rdData);
         checkOutput($sformatf("rst_rd_%02h", regAddrs[k]), rdData, 32'h0);
         checkOutput($sformatf("ack_drop_%02h", regAddrs[k]), 32'(ack), 32'h0);
      end

      // RX_CFG write while idle.
      wbWrite(5'h10, 32'h8001_0000, 4'hF);
      wbRead(5'h10, rdData);
      checkOutput("cfg_rd", rdData, 32'h8001_0000);
      checkOutput("cfg_out", rxCfg, 32'h8001_0000);

      // Enable: stays in SYNC (busy, state 1) until a WS falling edge.
      wbWrite(5'h00, 32'h0000_0001, 4'hF);
      wbRead(5'h04, rdData);
      checkOutput("sync_status", rdData, 32'h0000_0011);
      checkOutput("sync_rx_en", 32'(rxEn), 32'h0);
      ws = 1'b0;
      latency = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         latency++;
         if (rxEn) break;
      end
      checkOutput("en_latency_ok", 32'(latency >= 3 && latency <= 4), 32'h1);
      checkOutput("run_rx_en", 32'(rxEn), 32'h1);

      // Samples in RUN are counted; RX_CFG is locked while busy.
      for (int i = 0; i < 5; i++) begin
         sampleValid = 1'b1;
         waitCycles(1);
         sampleValid = 1'b0;
         waitCycles(1);
      end
      wbWrite(5'h10, 32'hFFFF_FFFF, 4'hF);
      checkOutput("cfg_locked", rxCfg, 32'h8001_0000);
      wbRead(5'h04, rdData);
      checkOutput("run_status", rdData, 32'h0000_0021);

      applyStimulus(32'h72);
      wbRead(5'h0C, rdData);
      checkOutput("frame_cnt_72", rdData, 32'h0000_0072);
      wbRead(5'h14, rdData);
      checkOutput("sample_cnt_5", rdData, 32'h0000_0005);

      // Disable written on the very edge that counts the next frame edge.
      ws = 1'b1;
      waitCycles(4);
      ws = 1'b0;
      waitCycles(2);
      wbWrite(5'h00, 32'h0000_0000, 4'hF);
      checkOutput("dis_rx_en", 32'(rxEn), 32'h0);
      wbRead(5'h0C, rdData);
      checkOutput("dis_edge_not_counted", rdData, 32'h0000_0072);
      wbRead(5'h04, rdData);
      checkOutput("dis_status_idle", rdData, 32'h0000_0000);

      // Samples outside RUN are ignored.
      sampleValid = 1'b1;
      waitCycles(1);
      sampleValid = 1'b0;
      waitCycles(1);
      wbRead(5'h14, rdData);
      checkOutput("sample_idle_ignored", rdData, 32'h0000_0005);

      // One-shot: target 4 frames, ie_done set.
      wbWrite(5'h08, 32'h0000_0004, 4'hF);
      wbWrite(5'h00, 32'h0000_0103, 4'hF);
      wbRead(5'h0C, rdData);
      checkOutput("oneshot_cnt_cleared", rdData, 32'h0000_0000);
      applyStimulus(5);
      wbRead(5'h04, rdData);
      checkOutput("oneshot_status_done", rdData, 32'h0000_0032);
      checkOutput("oneshot_rx_en", 32'(rxEn), 32'h0);
      checkOutput("oneshot_irq", 32'(irq), 32'h1);
      wbRead(5'h0C, rdData);
      checkOutput("oneshot_frames", rdData, 32'h0000_0004);
      wbWrite(5'h04, 32'h0000_0002, 4'hF);
      waitCycles(1);
      checkOutput("done_w1c_irq", 32'(irq), 32'h0);
      wbWrite(5'h00, 32'h0000_0000, 4'hF);

      // Byte enables: only byte 1 (interrupt enables) is written.
      wbWrite(5'h00, 32'h0000_0303, 4'b0010);
      wbRead(5'h00, rdData);
      checkOutput("ctrl_byte_en", rdData, 32'h0000_0300);

      // Overflow sets ovf and, with ie_ovf, the interrupt.
      overflow = 1'b1;
      waitCycles(1);
      overflow = 1'b0;
      waitCycles(2);
      checkOutput("ovf_irq", 32'(irq), 32'h1);
      wbRead(5'h04, rdData);
      checkOutput("ovf_status", rdData, 32'h0000_0004);

      // W1C of ovf landing on the same edge as a new overflow pulse.
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h04; datIn = 32'h0000_0004; sel = 4'hF;
      overflow = 1'b1;
      waitCycles(1);
      overflow = 1'b0;
      checkOutput("ovf_w1c_ack", 32'(ack), 32'h1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      waitCycles(1);
      wbRead(5'h04, rdData);
      checkOutput("ovf_set_wins", rdData, 32'h0000_0004);

      // Plain W1C clears ovf and the interrupt.
      wbWrite(5'h04, 32'h0000_0004, 4'hF);
      waitCycles(1);
      wbRead(5'h04, rdData);
      checkOutput("ovf_cleared", rdData, 32'h0000_0000);
      checkOutput("ovf_irq_cleared", 32'(irq), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
